// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780-style LCD write controller.
package lcd_pkg;

  // Bus-cycle sequencer states; INIT_DLY is only entered when LCD_INIT_EN is defined.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    PULSE    = 3'd2,
    HOLD     = 3'd3,
    WAIT     = 3'd4,
    INIT_DLY = 3'd5
  } lcd_state_e;

  // Bit positions inside the CPU-visible io_LCD register.
  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_BL_BIT   = 30;
  localparam int LCD_REQ_BIT  = 10;
  localparam int LCD_RS_BIT   = 9;
  localparam int LCD_DATA_MSB = 7;

  // Commands 0x00..0x03 with RS=0 are clear/home and need the long execution wait.
  localparam logic [7:0] CLR_HOME_MAX = 8'h03;

  // Power-on init sequence: 15 ms at 50 MHz, then six commands with RS=0.
  localparam int INIT_DLY_CYC = 750000;
  localparam int INIT_CNT_W   = 20;
  localparam int INIT_NUM     = 6;
  // Element 0 is issued first.
  localparam logic [INIT_NUM-1:0][7:0] INIT_ROM =
    {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

  // True when the latched write is a clear/home command.
  function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
    return (!rs) && (data <= CLR_HOME_MAX);
  endfunction

endpackage

// File: rtl/lcd_req_buf.sv
// lcd_req_buf: request-toggle edge detector plus a 1-deep pending buffer with
// a sticky overflow flag. The consumer either takes the selected entry
// (pending first, else the arrival) or leaves arrivals to be buffered.
module lcd_req_buf
  import lcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tog_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       take_i,
  output logic       req_o,
  output logic       sel_rs_o,
  output logic [7:0] sel_data_o,
  output logic       pend_vld_o,
  output logic       ovf_o
);

  logic       tog_q, tog_prev_q;
  logic       rs_q;
  logic [7:0] data_q;
  logic       pend_vld_q, pend_vld_d;
  logic       pend_rs_q, pend_rs_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic       ovf_q, ovf_d;
  logic       arr_s;

  // An arrival is a change of the sampled toggle bit between consecutive samples.
  assign arr_s      = tog_q ^ tog_prev_q;
  assign req_o      = pend_vld_q | arr_s;
  assign sel_rs_o   = pend_vld_q ? pend_rs_q   : rs_q;
  assign sel_data_o = pend_vld_q ? pend_data_q : data_q;
  assign pend_vld_o = pend_vld_q;
  assign ovf_o      = ovf_q;

  // Sample the CPU register once per clock; reset preloads both toggle samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tog_q      <= tog_i;
      tog_prev_q <= tog_i;
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      tog_q      <= tog_i;
      tog_prev_q <= tog_q;
      rs_q       <= rs_i;
      data_q     <= data_i;
    end
  end

  // Pending-slot bookkeeping: launch, refill, fill, or drop with overflow.
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_rs_d   = pend_rs_q;
    pend_data_d = pend_data_q;
    ovf_d       = ovf_q;
    if (take_i && pend_vld_q) begin
      if (arr_s) begin
        pend_rs_d   = rs_q;
        pend_data_d = data_q;
      end else begin
        pend_vld_d  = 1'b0;
      end
    end else if (take_i) begin
      pend_vld_d = 1'b0;
    end else if (arr_s) begin
      if (!pend_vld_q) begin
        pend_vld_d  = 1'b1;
        pend_rs_d   = rs_q;
        pend_data_d = data_q;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      pend_vld_d = pend_vld_q;
    end
  end

  // Pending slot and sticky overflow registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_vld_q  <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_rs_q   <= pend_rs_d;
      pend_data_q <= pend_data_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns toggle-requested CPU writes into timed HD44780 bus cycles
// (setup, EN pulse, hold, execution wait).
// Build macro LCD_INIT_EN: run the power-on init command sequence after reset.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP_CYC = 2,
  parameter int T_PULSE_CYC = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_CLEAR_CYC = 82000,
  parameter int CNT_W       = 17
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_LCD,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        lcd_blon,
  output logic        busy,
  output logic        ovf
);

`ifdef LCD_INIT_EN
  // The init delay needs more range than the command waits.
  localparam int CW = (CNT_W > INIT_CNT_W) ? CNT_W : INIT_CNT_W;
`else
  localparam int CW = CNT_W;
`endif

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          en_q, en_d;
  logic          on_q, blon_q;
  logic          req_s, take_s, sel_rs_s, pend_vld_s, ovf_s, init_act_s;
  logic [7:0]    sel_data_s;
  logic          unused_s;

`ifdef LCD_INIT_EN
  logic       init_act_q, init_act_d;
  logic [2:0] init_idx_q, init_idx_d;
  assign init_act_s = init_act_q;
`else
  assign init_act_s = 1'b0;
`endif

  assign unused_s = ^{io_LCD[29:11], io_LCD[8]};

  lcd_req_buf u_req_buf (
    .clk_i      (clk),
    .rst_i      (rst),
    .tog_i      (io_LCD[LCD_REQ_BIT]),
    .rs_i       (io_LCD[LCD_RS_BIT]),
    .data_i     (io_LCD[LCD_DATA_MSB:0]),
    .take_i     (take_s),
    .req_o      (req_s),
    .sel_rs_o   (sel_rs_s),
    .sel_data_o (sel_data_s),
    .pend_vld_o (pend_vld_s),
    .ovf_o      (ovf_s)
  );

  // Sequencer next state: each timed state loads period-1 and leaves at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    take_s  = 1'b0;
`ifdef LCD_INIT_EN
    init_act_d = init_act_q;
    init_idx_d = init_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (init_act_s) begin
`ifdef LCD_INIT_EN
          rs_d    = 1'b0;
          data_d  = INIT_ROM[init_idx_q];
          state_d = SETUP;
          cnt_d   = CW'(T_SETUP_CYC - 1);
          if (init_idx_q == 3'(INIT_NUM - 1)) begin
            init_act_d = 1'b0;
            init_idx_d = 3'd0;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
          end
`else
          state_d = IDLE;
`endif
        end else if (req_s) begin
          take_s  = 1'b1;
          rs_d    = sel_rs_s;
          data_d  = sel_data_s;
          state_d = SETUP;
          cnt_d   = CW'(T_SETUP_CYC - 1);
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = CW'(T_PULSE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CW'(T_HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = WAIT;
          cnt_d   = is_clear_home(rs_q, data_q) ? CW'(T_CLEAR_CYC - 1) : CW'(T_EXEC_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT, INIT_DLY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    en_d = (state_d == PULSE);
  end

  // Sequencer and pin registers; reset aborts any cycle in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef LCD_INIT_EN
      state_q    <= INIT_DLY;
      cnt_q      <= CW'(INIT_DLY_CYC - 1);
      init_act_q <= 1'b1;
      init_idx_q <= 3'd0;
`else
      state_q    <= IDLE;
      cnt_q      <= '0;
`endif
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
      en_q       <= 1'b0;
    end else begin
`ifdef LCD_INIT_EN
      init_act_q <= init_act_d;
      init_idx_q <= init_idx_d;
`endif
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
      en_q       <= en_d;
    end
  end

  // Power and backlight follow the CPU register one cycle later, outside the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      on_q   <= 1'b0;
      blon_q <= 1'b0;
    end else begin
      on_q   <= io_LCD[LCD_ON_BIT];
      blon_q <= io_LCD[LCD_BL_BIT];
    end
  end

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign lcd_on   = on_q;
  assign lcd_blon = blon_q;
  assign busy     = (state_q != IDLE) | pend_vld_s | init_act_s;
  assign ovf      = ovf_s;

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Downstream consumer of the core's memory-mapped io_LCD output register.
- Turns CPU writes into correctly timed HD44780-style bus cycles: RS/DATA setup, EN pulse width, hold, and command execution wait.
- Software no longer bit-bangs EN. Each toggle of a request bit launches one hardware write cycle.
- Sits between the processor top level and the board LCD pins.

Parameters:
- T_SETUP_CYC, 2, cycles RS/DATA are stable before EN rises.
- T_PULSE_CYC, 12, cycles EN is held high.
- T_HOLD_CYC, 2, cycles RS/DATA are held after EN falls.
- T_EXEC_CYC, 2000, busy wait after a normal command or data write (40 us at 50 MHz).
- T_CLEAR_CYC, 82000, busy wait after a clear/home command (1.64 ms at 50 MHz).
- CNT_W, 17, timing counter width. Must hold T_CLEAR_CYC.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- io_LCD  in  32  CPU LCD register.
  - [31] = LCD on.
  - [30] = backlight.
  - [10] = request toggle.
  - [9] = RS.
  - [7:0] = data.
- lcd_data  out  8  LCD data bus. Write-only.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  read/write. Tied 0 (write).
- lcd_en  out  1  enable strobe.
- lcd_on  out  1  registered copy of io_LCD[31].
- lcd_blon  out  1  registered copy of io_LCD[30].
- busy  out  1  high while a cycle is in flight or a request is pending.
- ovf  out  1  sticky: a request was dropped because the 1-deep pending buffer was full.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge). On the following edge:
  - lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_on=0, lcd_blon=0, busy=0, ovf=0.
  - State = IDLE, pending buffer empty.
  - Toggle tracker loads io_LCD[10], so no spurious request is issued.
  - Reset mid-cycle aborts immediately: EN drops the same edge and the pending request is discarded.
- Request detection: request = io_LCD[10] differs from the last sampled value (one sample per clk). A request captures {RS=io_LCD[9], DATA=io_LCD[7:0]}.
- lcd_on and lcd_blon follow io_LCD[31:30] with 1-cycle latency, independent of the FSM.
- FSM states: IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE. Each timed state loads the counter with its period-1 and leaves when the counter reaches 0.
  - IDLE: when a request is in the pending buffer or arriving this cycle, latch RS/DATA onto the pins and go to SETUP. A pending-buffer entry has priority over a new arrival; the new arrival then goes into the buffer.
  - SETUP: T_SETUP_CYC cycles, lcd_en=0.
  - PULSE: T_PULSE_CYC cycles, lcd_en=1.
  - HOLD: T_HOLD_CYC cycles, lcd_en=0. RS/DATA are unchanged.
  - WAIT: T_CLEAR_CYC if RS=0 and DATA<=8'h03 (clear/home), else T_EXEC_CYC.
- Latency: the first EN rise occurs T_SETUP_CYC+1 cycles after the toggle edge is sampled.
- Buffering:
  - A request arriving in any non-IDLE state fills the 1-deep pending buffer.
  - A request arriving while the buffer is full is dropped and ovf is set. ovf clears only on rst.
  - In the WAIT->IDLE cycle, a pending entry launches with no idle bubble (IDLE is transited in one cycle).
- busy = (state != IDLE) OR pending valid.
- Counter is CNT_W bits, count-down only, never wraps. Parameters must satisfy period >= 1.

Optional Feature:
- Macro: LCD_INIT_EN.
- Defined:
  - After reset, the block runs an internal init sequence before accepting CPU requests: wait 750000 cycles (15 ms), then commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (RS=0). Each uses the normal SETUP/PULSE/HOLD/WAIT timing.
  - busy=1 throughout the sequence.
  - CPU toggles during init are tracked and buffered per the normal buffering rules.
- Not defined: the block is ready in IDLE on the first cycle after reset.

Decomposition:
- Package lcd_pkg:
  - state enum {IDLE, SETUP, PULSE, HOLD, WAIT, INIT_DLY}.
  - io_LCD bit-index constants.
  - Clear/home threshold 8'h03.
  - Init command ROM constant array.
- Sub-module lcd_req_buf: toggle edge detect plus 1-deep pending register with ovf flag. The FSM and counter stay in lcd_ctrl.

Test Plan:
- Toggle io_LCD[10] with RS=1, DATA=8'h41 -> lcd_rs=1, lcd_data=0x41, lcd_en high for exactly 12 cycles starting 3 cycles after the toggle sample; busy drops after a 2000-cycle wait.
- RS=0, DATA=8'h01 -> WAIT lasts 82000 cycles; DATA=8'h38 -> WAIT lasts 2000 cycles.
- Three toggles spaced 10 cycles apart -> two EN pulses issued back to back (second launches the cycle after the first WAIT ends); ovf=1 after the third toggle.
- Assert rst while in PULSE -> lcd_en=0 and busy=0 on the next edge; no further pulses; ovf=0.
- io_LCD[31:30]=2'b11 with no toggle -> lcd_on=lcd_blon=1 after 1 cycle; lcd_en stays 0.
- LCD_INIT_EN defined -> after 750000 cycles, six EN pulses carry 38,38,38,0C,01,06; busy=1 until the last WAIT ends.
